// File: rtl/gmii_arp_injector.sv
// Inline GMII receive-path tap that forwards upstream traffic and, on request, injects a burst
// of self-generated ARP frames (preamble, 60-byte payload, on-the-fly FCS) between frame boundaries.
module gmii_arp_injector #(
   parameter int unsigned IFG_CLOCKS = 125000,
   parameter int unsigned REPEAT     = 3,
   parameter logic [15:0] OPCODE     = 16'h0003,
   parameter logic [31:0] SENDER_IP  = 32'h0000_0000,
   parameter logic [31:0] TARGET_IP  = 32'hFFFF_FFFF,
   parameter int unsigned DROP_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [47:0]       mac_address,
   input  logic              mac_valid,
   input  logic              trigger,
   input  logic [7:0]        up_data,
   input  logic              up_dv,
   input  logic              up_er,
   output logic [7:0]        down_data,
   output logic              down_dv,
   output logic              down_er,
   output logic              busy,
   output logic              done,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int unsigned    IFG_W    = $clog2(IFG_CLOCKS + 1);
   localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CLOCKS - 1);

   typedef enum logic [2:0] {
      S_PASS, S_WAIT_EOF, S_PRE, S_DATA, S_FCS, S_IFG, S_RESUME
   } state_t;

   state_t            state, state_n;
   logic [2:0]        trig_s;
   logic              trig_rise;
   logic              accept;
   logic [47:0]       mac_lat;
   logic [6:0]        byte_cnt;
   logic [IFG_W-1:0]  ifg_cnt;
   logic [7:0]        pkt_cnt;
   logic [31:0]       crc;
   logic              up_dv_q;
   logic              dropping;
   logic [479:0]      payload;
   logic [5:0]        rev_idx;
   logic [7:0]        pay_byte;
   logic [7:0]        fcs_byte;
   logic [7:0]        data_n;
   logic              dv_n, er_n, done_n;

   // Reflected CRC-32, one byte LSB-first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   assign payload = {48'hFFFF_FFFF_FFFF, mac_lat, 16'h0806, 16'h0001, 16'h0800, 16'h0604,
                     OPCODE, mac_lat, SENDER_IP, 48'h0, TARGET_IP, 144'h0};
   assign rev_idx   = 6'd59 - 6'(byte_cnt - 7'd8);
   assign pay_byte  = 8'(payload >> {rev_idx, 3'b000});
   assign fcs_byte  = ~crc[{byte_cnt[1:0], 3'b000} +: 8];
   assign trig_rise = trig_s[1] & ~trig_s[2];
   assign busy      = (state != S_PASS);
   assign dropping  = state inside {S_PRE, S_DATA, S_FCS, S_IFG, S_RESUME};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_PASS;
      else     state <= state_n;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_n = state;
      data_n  = 8'h00;
      dv_n    = 1'b0;
      er_n    = 1'b0;
      done_n  = 1'b0;
      accept  = 1'b0;
      case (state)
         S_PASS: begin
            data_n = up_data;
            dv_n   = up_dv;
            er_n   = up_er;
            if (trig_rise && mac_valid) begin
               accept  = 1'b1;
               state_n = S_WAIT_EOF;
            end
         end
         S_WAIT_EOF: begin
            if (up_dv) begin
               data_n = up_data;
               dv_n   = 1'b1;
               er_n   = up_er;
            end else begin
               state_n = S_PRE;
            end
         end
         S_PRE: begin
            dv_n   = 1'b1;
            data_n = (byte_cnt == 7'd7) ? 8'hD5 : 8'h55;
            if (byte_cnt == 7'd7) state_n = S_DATA;
         end
         S_DATA: begin
            dv_n   = 1'b1;
            data_n = pay_byte;
            if (byte_cnt == 7'd67) state_n = S_FCS;
         end
         S_FCS: begin
            dv_n   = 1'b1;
            data_n = fcs_byte;
            if (byte_cnt == 7'd71) state_n = S_IFG;
         end
         S_IFG: begin
            if (ifg_cnt == IFG_LAST)
               state_n = (({1'b0, pkt_cnt} + 9'd1) < 9'(REPEAT)) ? S_PRE : S_RESUME;
         end
         S_RESUME: begin
            if (!up_dv) begin
               state_n = S_PASS;
               done_n  = 1'b1;
            end
         end
         default: state_n = S_PASS;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         down_data <= 8'h00;
         down_dv   <= 1'b0;
         down_er   <= 1'b0;
         done      <= 1'b0;
         trig_s    <= 3'b000;
         up_dv_q   <= 1'b0;
         mac_lat   <= 48'h0;
         byte_cnt  <= 7'd0;
         ifg_cnt   <= '0;
         pkt_cnt   <= 8'd0;
         crc       <= 32'hFFFF_FFFF;
         drop_cnt  <= '0;
      end else begin
         down_data <= data_n;
         down_dv   <= dv_n;
         down_er   <= er_n;
         done      <= done_n;
         trig_s    <= {trig_s[1:0], trigger};
         up_dv_q   <= up_dv;
         if (accept) mac_lat <= mac_address;

         // One byte counter spans preamble, payload and FCS (0..71).
         if (state inside {S_PRE, S_DATA, S_FCS})
            byte_cnt <= (byte_cnt == 7'd71) ? 7'd0 : byte_cnt + 7'd1;
         else
            byte_cnt <= 7'd0;

         if (state == S_PRE)       crc <= 32'hFFFF_FFFF;
         else if (state == S_DATA) crc <= crc_byte(crc, pay_byte);

         if (state == S_IFG) ifg_cnt <= ifg_cnt + IFG_W'(1);
         else                ifg_cnt <= '0;

         if (state == S_WAIT_EOF)
            pkt_cnt <= 8'd0;
         else if (state == S_IFG && ifg_cnt == IFG_LAST)
            pkt_cnt <= pkt_cnt + 8'd1;

         if (dropping && up_dv && !up_dv_q && drop_cnt != {DROP_W{1'b1}})
            drop_cnt <= drop_cnt + DROP_W'(1);
      end
   end

endmodule
